mem_wait_sram: RTL and testbench
================================

# mem_wait_sram

Word-addressed on-chip SRAM slave that sits directly downstream of the core's native memory port (mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata). It serves instruction fetches and data accesses with a programmable, fixed wait-state latency. It applies byte-strobed writes exactly once per handshake and reports out-of-range accesses and core-side protocol violations. Formal and simulation benches use it as the reference memory behind the core.

## Interface
- DEPTH_LOG2, default 10: SRAM depth is 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, default 32'h0000_0000: byte address of word 0; must be aligned to 4·2^DEPTH_LOG2.
- WAIT_CYCLES, default 2: extra stall cycles per access, 0..15.

- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- mem_valid  in  1  request valid; held until mem_ready.
- mem_instr  in  1  request is a fetch (informational; counted only).
- mem_addr  in  32  byte address; bits [1:0] ignored (aligned accesses).
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 0 = read.
- mem_ready  out  1  one-cycle handshake pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- mem_fault  out  1  pulses with mem_ready when the access was out of range.
- proto_err  out  1  sticky; set on a core protocol violation.
- fetch_count  out  32  completed fetch handshakes, wraps at 2^32.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if mem_valid, latch addr/wdata/wstrb/instr, load cnt=WAIT_CYCLES, go to WAIT; otherwise stay.
- WAIT, cnt≠0: cnt decrements.
- WAIT, cnt=0: go to RESP and assert mem_ready (registered).
  - In range and wstrb≠0: write the strobed bytes at this edge; mem_rdata=0.
  - In range and wstrb=0: mem_rdata = the word stored before this edge.
  - Out of range (word index outside [0, 2^DEPTH_LOG2)): no write, mem_rdata=0, mem_fault=1.
- RESP: mem_ready, mem_fault and mem_rdata return to 0; go to IDLE. A mem_valid present in RESP is ignored. It is accepted in the following IDLE cycle.
- Protocol check in WAIT:
  - If mem_valid drops, or addr/wdata/wstrb differ from the latched values, set proto_err.
  - Abandon the access: no write, no mem_ready, return to IDLE.
- fetch_count increments on every mem_ready cycle whose latched instr=1, including faulting fetches.
- Address range: word index = (mem_addr − BASE_ADDR) >> 2, computed in 32 bits. Addresses below BASE_ADDR wrap to large indices and therefore fault.
- Memory contents are not reset. Only control state is reset.

## Timing
- Reset (resetn=0 at an edge): state=IDLE, cnt=0, mem_ready=0, mem_rdata=0, mem_fault=0, proto_err=0, fetch_count=0.
- Reset mid-access: the access is abandoned with no write, even if reset coincides with the WAIT cnt=0 edge.
- Latency: if mem_valid is first seen in IDLE at cycle t, mem_ready=1 at cycle t+WAIT_CYCLES+2, for exactly one cycle.
- Back-to-back requests: the minimum request-to-request period is WAIT_CYCLES+3 cycles.
- mem_ready is never asserted twice for one request, and never asserted without a preceding accepted request.
- mem_rdata, mem_fault and mem_ready are all registered outputs. There is no combinational input-to-output path.
- proto_err clears only on reset.

## Test plan
- Reset, then write 32'hDEADBEEF with wstrb=4'hF to BASE_ADDR+8, then read the same address with WAIT_CYCLES=2 → each mem_ready occurs 4 cycles after valid; the read returns 32'hDEADBEEF.
- Byte strobe: write 32'h11223344 with wstrb=4'b0101 over 32'hFFFFFFFF, then read → 32'hFF22FF44.
- Out of range: read BASE_ADDR + 4·2^DEPTH_LOG2 → mem_ready and mem_fault both pulse; mem_rdata=0; no SRAM word is altered.
- Protocol: drop mem_valid one cycle into WAIT during a write → proto_err=1 and stays 1; no mem_ready; the target word is unchanged on read-back.
- WAIT_CYCLES=0 with 3 consecutive fetches, valid held high throughout → mem_ready at t+2, t+5, t+8; fetch_count=3.
- Assert reset on the WAIT cnt=0 cycle of a write → no write, all outputs 0 in the next cycle, fetch_count=0.

Source files
------------

// File: rtl/mem_wait_sram.sv
// rtl/mem_wait_sram.sv - word-addressed SRAM slave with fixed wait states on the core's native memory port
//
// Purpose: serves fetches and data accesses after WAIT_CYCLES stall cycles.
// Strobed writes are applied exactly once per handshake. Accesses outside the
// array raise mem_fault. Request changes while the access waits raise proto_err.
//
// Parameters:
//   DEPTH_LOG2  - array holds 2^DEPTH_LOG2 32-bit words
//   BASE_ADDR   - byte address of word 0, aligned to the array size
//   WAIT_CYCLES - extra stall cycles per access, 0..15
//
// Ports:
//   clk, resetn  - clock, synchronous active-low reset (control state only)
//   mem_valid    - request valid, held until mem_ready
//   mem_instr    - request is a fetch; only used for fetch_count
//   mem_addr     - byte address; bits [1:0] do not select the word
//   mem_wdata    - write data
//   mem_wstrb    - byte write enables; 0 means read
//   mem_ready    - one-cycle registered handshake pulse
//   mem_rdata    - read data, non-zero only while mem_ready=1
//   mem_fault    - pulses with mem_ready for an out-of-range access
//   proto_err    - sticky; the request was dropped or changed while waiting
//   fetch_count  - completed fetch handshakes, wraps at 2^32
module mem_wait_sram #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_fault,
  output logic        proto_err,
  output logic [31:0] fetch_count
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_CYCLES);
  // BASE_ADDR is array-aligned, so subtracting word addresses in 30 bits
  // equals the 32-bit byte difference shifted right by two.
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        lat_instr;

  logic accept;
  logic viol;
  logic do_resp;

  logic [29:0]           word_idx;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] mem_idx;

  logic [31:0] mem [0:DEPTH-1];

  // Addresses below BASE_ADDR wrap to huge indices and land out of range.
  assign word_idx = lat_addr[31:2] - BASE_WORD;
  assign in_range = (word_idx >> DEPTH_LOG2) == 30'd0;
  assign mem_idx  = word_idx[DEPTH_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    viol      = 1'b0;
    do_resp   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          accept    = 1'b1;
          cnt_nxt   = WAIT_CNT;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A violation outranks the final wait cycle: the access is abandoned.
        if (!mem_valid || mem_addr != lat_addr || mem_wdata != lat_wdata ||
            mem_wstrb != lat_wstrb) begin
          viol      = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          do_resp   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        // Any request showing up here is taken in the following IDLE cycle.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr  <= mem_addr;
      lat_wdata <= mem_wdata;
      lat_wstrb <= mem_wstrb;
      lat_instr <= mem_instr;
    end
  end

  // Reset gates the write so an access cut short on its final edge is lost.
  always_ff @(posedge clk) begin
    if (resetn && do_resp && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'd0;
      mem_fault   <= 1'b0;
      proto_err   <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      mem_ready <= do_resp;
      mem_fault <= do_resp && !in_range;
      mem_rdata <= 32'd0;
      if (do_resp && in_range && lat_wstrb == 4'd0) begin
        mem_rdata <= mem[mem_idx];
      end
      if (viol) begin
        proto_err <= 1'b1;
      end
      if (do_resp && lat_instr) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_sram.sv
// tb/tb_mem_wait_sram.sv - self-checking bench for mem_wait_sram
module tb_mem_wait_sram;

  localparam int          DL    = 4;
  localparam int          NW    = 1 << DL;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          W     = 2;

  logic        clk;
  logic        resetn;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_fault, proto_err;
  logic [31:0] mem_rdata, fetch_count;

  logic        v1, i1;
  logic [31:0] a1, wd1;
  logic [3:0]  ws1;
  logic        rdy1, flt1, perr1;
  logic [31:0] rd1, fc1;

  mem_wait_sram #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
    .proto_err(proto_err), .fetch_count(fetch_count)
  );

  mem_wait_sram #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(v1), .mem_instr(i1),
    .mem_addr(a1), .mem_wdata(wd1), .mem_wstrb(ws1),
    .mem_ready(rdy1), .mem_rdata(rd1), .mem_fault(flt1),
    .proto_err(perr1), .fetch_count(fc1)
  );

  typedef struct {
    int          rc;
    logic [31:0] rd;
    logic        flt;
    logic        ins;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  logic [31:0] model_mem [NW];
  int          last_ready;
  int          cyc;
  int          checks;
  int          failures;
  bit          chk_on;
  bit          exp_rdy;
  logic [31:0] fc_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the request is taken at the first cycle the slave is free,
  // answers WAIT+2 cycles later, and reads/writes a plain word array.
  task automatic push_exp(input int a, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] ws, input logic ins);
    logic [31:0] off;
    int          idx;
    exp_t        e;
    off   = ad - BASE;
    e.rc  = a + W + 2;
    e.ins = ins;
    e.rd  = 32'd0;
    e.flt = (off >> 2) >= NW;
    if (!e.flt) begin
      idx = int'(off >> 2);
      if (ws == 4'd0) e.rd = model_mem[idx];
      else
        for (int b = 0; b < 4; b++)
          if (ws[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    exp_q.push_back(e);
    last_ready = e.rc;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      exp_rdy = exp_q.size() > 0 && exp_q[0].rc == cyc;
      chk("mem_ready", 32'(mem_ready), 32'(exp_rdy));
      if (exp_rdy) begin
        ce = exp_q.pop_front();
        if (ce.ins) fc_exp = fc_exp + 32'd1;
        chk("mem_rdata", mem_rdata, ce.rd);
        chk("mem_fault", 32'(mem_fault), 32'(ce.flt));
        chk("fetch_count", fetch_count, fc_exp);
      end else begin
        chk("rdata_quiet", mem_rdata, 32'd0);
        chk("fault_quiet", 32'(mem_fault), 32'd0);
      end
      if (exp_q.size() > 0 && exp_q[0].rc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_ready actual=none required=cycle %0d", exp_q[0].rc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input int p, output logic [31:0] rd, output logic flt, output int lat);
    int n;
    n   = 0;
    rd  = 32'd0;
    flt = 1'b0;
    lat = -1;
    while (1) begin
      @(negedge clk);
      n++;
      if (mem_ready) begin
        rd  = mem_rdata;
        flt = mem_fault;
        lat = cyc - p;
        break;
      end
      if (n > 60) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic access(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins, output logic [31:0] rd, output logic flt, output int lat);
    int p;
    p         = cyc;
    mem_valid = 1'b1;
    mem_addr  = ad;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_instr = ins;
    push_exp((p > last_ready + 1) ? p : last_ready + 1, ad, wd, ws, ins);
    wait_ready(p, rd, flt, lat);
  endtask

  logic [31:0] rd, ad, wd;
  logic [3:0]  ws;
  logic        flt;
  int          lat, p, sel;
  int          rt[$];
  int          el[3];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; chk_on = 0; fc_exp = 32'd0; last_ready = -100;
    resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    v1 = 1'b0; i1 = 1'b0; a1 = 32'd0; wd1 = 32'd0; ws1 = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    resetn = 1'b1;
    chk_on = 1;
    @(negedge clk);

    for (int i = 0; i < NW; i++) access(BASE + 32'(4 * i), $urandom, 4'hF, 1'b0, rd, flt, lat);

    repeat (2) @(negedge clk);
    access(BASE + 32'd8, 32'hDEADBEEF, 4'hF, 1'b0, rd, flt, lat);
    chk("write_latency", 32'(lat), 32'd4);
    repeat (2) @(negedge clk);
    access(BASE + 32'd8, 32'd0, 4'h0, 1'b1, rd, flt, lat);
    chk("read_latency", 32'(lat), 32'd4);
    chk("read_deadbeef", rd, 32'hDEADBEEF);

    access(BASE + 32'd12, 32'hFFFFFFFF, 4'hF, 1'b0, rd, flt, lat);
    access(BASE + 32'd12, 32'h11223344, 4'b0101, 1'b0, rd, flt, lat);
    access(BASE + 32'd12, 32'd0, 4'h0, 1'b0, rd, flt, lat);
    chk("strobe_merge", rd, 32'hFF22FF44);

    access(BASE + 32'(4 * NW), 32'd0, 4'h0, 1'b1, rd, flt, lat);
    chk("oor_fault", 32'(flt), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    access(BASE + 32'(4 * NW), 32'h0BAD0BAD, 4'hF, 1'b0, rd, flt, lat);
    access(BASE - 32'd4, 32'h0BAD0BAD, 4'hF, 1'b0, rd, flt, lat);
    chk("below_base_fault", 32'(flt), 32'd1);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) ad = BASE + 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3));
      else if (sel == 8) ad = BASE + 32'(4 * NW) + 32'($urandom_range(0, 255));
      else ad = BASE - 32'(4 * $urandom_range(1, 8));
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      access(ad, $urandom, ws, 1'($urandom), rd, flt, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < NW; i++) access(BASE + 32'(4 * i), 32'd0, 4'h0, 1'b0, rd, flt, lat);

    // valid drops one cycle into WAIT during a write
    repeat (2) @(negedge clk);
    chk("proto_err_before", 32'(proto_err), 32'd0);
    p = cyc;
    mem_valid = 1'b1; mem_addr = BASE + 32'd20; mem_wdata = 32'hCAFEF00D;
    mem_wstrb = 4'hF; mem_instr = 1'b0;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("proto_err_drop", 32'(proto_err), 32'd1);
    repeat (6) @(negedge clk);
    last_ready = -100;
    access(BASE + 32'd20, 32'd0, 4'h0, 1'b0, rd, flt, lat);

    // wdata changes while waiting: abandoned, then retaken as a new request
    repeat (2) @(negedge clk);
    p = cyc;
    mem_valid = 1'b1; mem_addr = BASE + 32'd24; mem_wdata = 32'h12345678;
    mem_wstrb = 4'hF; mem_instr = 1'b1;
    @(negedge clk);
    mem_wdata = 32'h87654321;
    push_exp(p + 2, BASE + 32'd24, 32'h87654321, 4'hF, 1'b1);
    wait_ready(p, rd, flt, lat);
    chk("retake_latency", 32'(lat), 32'd6);
    access(BASE + 32'd24, 32'd0, 4'h0, 1'b0, rd, flt, lat);
    chk("retake_data", rd, 32'h87654321);
    chk("proto_err_sticky", 32'(proto_err), 32'd1);

    // reset lands on the final wait edge of a write
    repeat (2) @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE + 32'd28; mem_wdata = 32'h55AA55AA;
    mem_wstrb = 4'hF; mem_instr = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    fc_exp = 32'd0;
    chk("midrst_ready", 32'(mem_ready), 32'd0);
    chk("midrst_rdata", mem_rdata, 32'd0);
    chk("midrst_fault", 32'(mem_fault), 32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    chk("midrst_fetch_count", fetch_count, 32'd0);
    resetn = 1'b1; mem_valid = 1'b0;
    last_ready = -100;
    @(negedge clk);
    access(BASE + 32'd28, 32'd0, 4'h0, 1'b0, rd, flt, lat);

    // zero-wait instance: three fetches with valid held high
    @(negedge clk);
    p = cyc;
    v1 = 1'b1; i1 = 1'b1; a1 = BASE + 32'd4;
    for (int k = 0; k < 14 && rt.size() < 3; k++) begin
      @(negedge clk);
      if (rdy1) rt.push_back(cyc - p);
    end
    v1 = 1'b0;
    el = '{2, 5, 8};
    for (int k = 0; k < 3; k++) chk("w0_ready_time", 32'((k < rt.size()) ? rt[k] : -1), 32'(el[k]));
    @(negedge clk);
    chk("w0_fetch_count", fc1, 32'd3);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
